// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Purpose  : WS2812 line timing at 20 MHz and the receive decoder state type.
// Revision : 1.0
// ============================================================================
package ws2812_pkg;

    localparam int T0H   = 8;
    localparam int T1H   = 16;
    localparam int T_BIT = 25;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        HIGH   = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ws2812_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic 1-bit double-flop synchroniser for an asynchronous input.
// Revision : 1.0
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx
// Purpose  : Decodes one WS2812 line into 24-bit pixels, frame ends and errors.
// Revision : 1.0
// ============================================================================
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_BIT_THRESH = 12,
    parameter int T_HIGH_MIN   = 3,
    parameter int T_HIGH_MAX   = 22,
    parameter int T_RESET      = 1000,
    parameter int MAX_PIXELS   = 512
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sdi,
    input  logic                              err_clear,
    output logic [23:0]                       pixel_data,
    output logic                              pixel_valid,
    output logic                              frame_end,
    output logic [$clog2(MAX_PIXELS+1)-1:0]   pixel_count,
    output logic                              err_glitch,
    output logic                              err_long,
    output logic                              err_partial
);

    localparam int LW = $clog2(T_RESET + 1);
    localparam int WW = $clog2(T_HIGH_MAX + 2);
    localparam int CW = $clog2(MAX_PIXELS + 1);

    localparam logic [LW-1:0] C_LOW_ONE  = LW'(1);
    localparam logic [LW-1:0] C_LOW_MAX  = LW'(T_RESET);
    localparam logic [LW-1:0] C_LOW_LAST = LW'(T_RESET - 1);
    localparam logic [WW-1:0] C_W_ONE    = WW'(1);
    localparam logic [WW-1:0] C_W_MIN    = WW'(T_HIGH_MIN);
    localparam logic [WW-1:0] C_W_MAX    = WW'(T_HIGH_MAX);
    localparam logic [WW-1:0] C_W_THR    = WW'(T_BIT_THRESH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(MAX_PIXELS);
    localparam logic [4:0]    C_IDX_LAST = 5'd23;

    logic sdi_s;
    logic rise;
    logic bit_val;
    logic glitch_ev, long_ev, partial_ev;

    rx_state_e state_q, state_d;
    logic [LW-1:0] low_q, low_d;
    logic [WW-1:0] width_q, width_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [22:0]   shift_q, shift_d;
    logic          sdi_q;
    logic [23:0]   pixel_data_q, pixel_data_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          frame_end_q, frame_end_d;
    logic [CW-1:0] pixel_count_q, pixel_count_d;
    logic          err_glitch_q, err_glitch_d;
    logic          err_long_q, err_long_d;
    logic          err_partial_q, err_partial_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (sdi),
        .o_q (sdi_s)
    );

    assign rise    = sdi_s & ~sdi_q;
    assign bit_val = (width_q >= C_W_THR);

    always_comb begin
        state_d       = state_q;
        low_d         = low_q;
        width_d       = width_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        frame_end_d   = 1'b0;
        pixel_count_d = pixel_count_q;
        glitch_ev     = 1'b0;
        long_ev       = 1'b0;
        partial_ev    = 1'b0;

        case (state_q)
            RESYNC: begin
                bit_idx_d = '0;
                if (sdi_s) begin
                    low_d = '0;
                end else if (low_q >= C_LOW_LAST) begin
                    low_d         = C_LOW_MAX;
                    state_d       = IDLE;
                    frame_end_d   = 1'b1;
                    pixel_count_d = '0;
                end else begin
                    low_d = low_q + C_LOW_ONE;
                end
            end
            IDLE: begin
                if (rise) begin
                    width_d = C_W_ONE;
                    state_d = HIGH;
                end else if (low_q != C_LOW_MAX) begin
                    // Counter parks at T_RESET so frame_end fires once per gap.
                    low_d = low_q + C_LOW_ONE;
                    if (low_q == C_LOW_LAST) begin
                        frame_end_d   = 1'b1;
                        pixel_count_d = '0;
                        bit_idx_d     = '0;
                        partial_ev    = (bit_idx_q != 5'd0);
                    end
                end
            end
            HIGH: begin
                // sdi_q is always 1 while in HIGH, so a low sdi_s is the falling edge.
                if (sdi_s) begin
                    if (width_q >= C_W_MAX) begin
                        long_ev   = 1'b1;
                        state_d   = RESYNC;
                        low_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        width_d = width_q + C_W_ONE;
                    end
                end else begin
                    low_d = C_LOW_ONE;
                    if (width_q < C_W_MIN) begin
                        glitch_ev = 1'b1;
                        state_d   = RESYNC;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        shift_d = {shift_q[21:0], bit_val};
                        if (bit_idx_q == C_IDX_LAST) begin
                            pixel_data_d  = {shift_q, bit_val};
                            pixel_valid_d = 1'b1;
                            bit_idx_d     = '0;
                            if (pixel_count_q != C_CNT_MAX) begin
                                pixel_count_d = pixel_count_q + C_CNT_ONE;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + 5'd1;
                        end
                    end
                end
            end
            default: state_d = RESYNC;
        endcase

        // A new error in the same cycle as err_clear stays set.
        err_glitch_d  = (err_glitch_q  & ~err_clear) | glitch_ev;
        err_long_d    = (err_long_q    & ~err_clear) | long_ev;
        err_partial_d = (err_partial_q & ~err_clear) | partial_ev;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RESYNC;
            low_q         <= '0;
            width_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            sdi_q         <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            pixel_count_q <= '0;
            err_glitch_q  <= 1'b0;
            err_long_q    <= 1'b0;
            err_partial_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            low_q         <= low_d;
            width_q       <= width_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            sdi_q         <= sdi_s;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            frame_end_q   <= frame_end_d;
            pixel_count_q <= pixel_count_d;
            err_glitch_q  <= err_glitch_d;
            err_long_q    <= err_long_d;
            err_partial_q <= err_partial_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_end   = frame_end_q;
    assign pixel_count = pixel_count_q;
    assign err_glitch  = err_glitch_q;
    assign err_long    = err_long_q;
    assign err_partial = err_partial_q;

endmodule
`default_nettype wire

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-line serial LED data decoder: the receive end of the waveform the parallel string drivers put on each led_sdi pin.
- Measures high-pulse widths on one sdi line and reconstructs 24-bit pixel words, frame boundaries and protocol errors.
- Runs on clk_20. Used as a loopback checker on spare pins and as the per-string monitor in string-level benches.

Parameters:
- T_BIT_THRESH, 12: high width in cycles; a width at or above this value decodes as 1, below as 0.
- T_HIGH_MIN, 3: a high pulse shorter than this is a glitch.
- T_HIGH_MAX, 22: a high pulse longer than this is an error.
- T_RESET, 1000: low cycles that constitute a latch/reset (50 us at 20 MHz).
- MAX_PIXELS, 512: pixel_count saturates at this value.

Ports:
- clk  in  1  20 MHz clock.
- reset  in  1  asynchronous, active-high reset.
- sdi  in  1  asynchronous serial LED data line.
- pixel_data  out  24  last complete pixel, MSB first as received (GRB order, not reordered).
- pixel_valid  out  1  one-cycle strobe; pixel_data is valid in that cycle.
- frame_end  out  1  one-cycle strobe when a latch/reset low period completes.
- pixel_count  out  clog2(MAX_PIXELS+1)  pixels received in the current frame; saturating.
- err_glitch  out  1  sticky: a high pulse was shorter than T_HIGH_MIN.
- err_long  out  1  sticky: a high pulse was longer than T_HIGH_MAX.
- err_partial  out  1  sticky: a frame ended with 1-23 bits pending.
- err_clear  in  1  synchronous; clears all sticky errors.

Behaviour:
- Synchronisation: sdi passes through a 2-flop synchroniser to give sdi_s; sdi_q is sdi_s delayed one cycle. Edges are taken from sdi_s vs sdi_q.
- Reset values: all outputs 0. The FSM enters RESYNC with its counters at 0.
- RESYNC:
  - Counts consecutive low cycles on sdi_s; any high sample clears the count.
  - At count == T_RESET: go to IDLE, pulse frame_end, clear pixel_count.
  - The decoder never decodes before one full reset gap has been seen.
- IDLE:
  - On a rising edge: width counter = 1, go to HIGH.
  - Otherwise count low cycles. At T_RESET, pulse frame_end and clear pixel_count and the bit index (stays in IDLE).
  - frame_end pulses only once per low period; the counter holds at T_RESET.
- HIGH:
  - Width increments each cycle sdi_s is 1.
  - If width exceeds T_HIGH_MAX: set err_long, discard partial bits, go to RESYNC.
  - On a falling edge with width < T_HIGH_MIN: set err_glitch, discard partial bits, go to RESYNC.
  - Otherwise on the falling edge: shift bit (width >= T_BIT_THRESH) into the shift register, bit_idx++, go to IDLE.
- Pixel completion:
  - On the falling edge that completes bit 24: in the next cycle pixel_data is loaded, pixel_valid = 1 and pixel_count++ (saturating at MAX_PIXELS).
  - bit_idx wraps to 0.
  - Latency is 3 cycles from the sdi falling edge: 2 synchroniser cycles plus 1 register.
- End-of-frame with bits pending: if T_RESET is reached in IDLE with bit_idx != 0, set err_partial, drop the bits and still pulse frame_end.
- Simultaneous events:
  - err_clear together with an error event: the error wins (stays set).
  - pixel_valid and frame_end cannot coincide, because T_RESET > 1.
- Widths:
  - Low counter is clog2(T_RESET+1) bits.
  - Width counter is clog2(T_HIGH_MAX+2) bits and saturates.
- Reset mid-frame: asserting reset aborts immediately; outputs return to 0 and the FSM returns to RESYNC.

Decomposition:
- Package ws2812_pkg holds:
  - default timing constants for 20 MHz (T0H=8, T1H=16, T_BIT=25 cycles);
  - the FSM state enum (RESYNC, IDLE, HIGH).
- These constants are shared with the parallel string drivers.
- One sub-module is natural: sync_2ff (the generic 1-bit double-flop synchroniser).

Test Plan:
- Hold sdi low 1000 cycles, then send one pixel 0xA5C30F (high 8/16 cycles, bit period 25), then low 1000 cycles -> pixel_valid once with 0xA5C30F; pixel_count=1; then frame_end; pixel_count=0.
- 128 pixels of a counting pattern followed by a reset gap -> 128 pixel_valid strobes in order, with data matching; pixel_count reaches 128 before frame_end.
- Mid-pixel 2-cycle high pulse -> err_glitch=1; no pixel_valid until after a 1000-cycle low; the next pixel decodes correctly.
- 30-cycle high pulse -> err_long=1, state RESYNC. err_clear pulse -> all errors 0.
- 10 bits, then 1000 low cycles -> err_partial=1, frame_end pulses, no pixel_valid.
- Threshold edges: high widths of 11 and 12 cycles -> decode as 0 and 1. Assert reset mid-pixel -> all outputs 0 next cycle; 1000 low cycles are required before the next decode.
